// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline constants and hazard controller state encoding
package hazard_ctrl_pkg;

  localparam int          REG_W         = 5;
  localparam int          CTRL_W_P      = 4;
  localparam logic [3:0]  CTRL_BUBBLE_P = 4'b1111;
  localparam int          CNT_W_P       = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall / branch flush controller for the ID stage
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int                CTRL_W      = CTRL_W_P,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_BUBBLE_P,
  parameter int                CNT_W       = CNT_W_P
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_W-1:0]  ID_RSaddr1_i,
  input  logic [REG_W-1:0]  ID_RSaddr2_i,
  input  logic              ID_uses_rs2_i,
  input  logic [CTRL_W-1:0] EX_control_i,
  input  logic              EX_memread_i,
  input  logic [REG_W-1:0]  EX_RDaddr_i,
  input  logic              branch_taken_i,
  output logic              hazard_o,
  output logic              pc_write_o,
  output logic              IF_ID_write_o,
  output logic              IF_ID_flush_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic              err_o
);

  hz_state_e r_state;
  hz_state_e w_state_nxt;
  logic      r_err;
  logic      w_lu_raw;
  logic      w_stall_issue;
  logic      w_flush_issue;

  // Bubbles and x0 never produce a real value, so neither can be a hazard source.
  assign w_lu_raw = EX_memread_i
                 && (EX_control_i != CTRL_BUBBLE)
                 && (EX_RDaddr_i != '0)
                 && ((EX_RDaddr_i == ID_RSaddr1_i)
                     || (ID_uses_rs2_i && (EX_RDaddr_i == ID_RSaddr2_i)));

  assign w_flush_issue = !rst_i && branch_taken_i;
  assign w_stall_issue = !rst_i && !branch_taken_i && w_lu_raw;

  always_comb begin
    w_state_nxt   = ST_RUN;
    hazard_o      = 1'b0;
    pc_write_o    = 1'b1;
    IF_ID_write_o = 1'b1;
    IF_ID_flush_o = 1'b0;
    if (rst_i) begin
      hazard_o      = 1'b1;
      pc_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      IF_ID_flush_o = 1'b1;
    end else if (branch_taken_i) begin
      w_state_nxt   = ST_FLUSH;
      hazard_o      = 1'b1;
      IF_ID_flush_o = 1'b1;
    end else if (w_lu_raw) begin
      w_state_nxt   = ST_STALL;
      hazard_o      = 1'b1;
      pc_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A repeat load-use on the cycle after a stall means the bubble never reached EX.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_lu_raw && (r_state == ST_STALL)) begin
      r_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_issue),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_flush_issue),
    .cnt_o (flush_cnt_o)
  );

  assign state_o = r_state;
  assign err_o   = r_err;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core. It generates the bubble-request (hazard) consumed by the ID/EX pipeline register, plus PC and IF/ID write enables, and the IF/ID flush.
- Detects load-use dependences between the instruction in ID and the instruction in EX.
- Handles taken-branch flushes.
- Keeps a small FSM and saturating stall/flush event counters for debug and performance visibility.
- Sits beside the ID stage: inputs come from ID decode and ID/EX outputs; outputs go to the PC, IF/ID and ID/EX.

Parameters:
- CTRL_W, 4, width of the ID/EX control field.
- CTRL_BUBBLE, 4'b1111, control encoding of a bubble in EX.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ID_RSaddr1_i  in  5  rs1 of the instruction in ID.
- ID_RSaddr2_i  in  5  rs2 of the instruction in ID.
- ID_uses_rs2_i  in  1  the ID instruction reads rs2 (R-type, store, branch).
- EX_control_i  in  CTRL_W  control_o of ID/EX.
- EX_memread_i  in  1  the EX instruction is a load.
- EX_RDaddr_i  in  5  RDaddr_o of ID/EX.
- branch_taken_i  in  1  branch resolved taken this cycle.
- hazard_o  out  1  to ID/EX hazard_i; forces a bubble on the next edge.
- pc_write_o  out  1  PC update enable.
- IF_ID_write_o  out  1  IF/ID load enable.
- IF_ID_flush_o  out  1  IF/ID clear.
- state_o  out  2  current FSM state.
- stall_cnt_o  out  CNT_W  load-use stalls taken.
- flush_cnt_o  out  CNT_W  branch flushes taken.
- err_o  out  1  sticky protocol error.

Behaviour:
- lu_raw (combinational) = EX_memread_i AND (EX_control_i != CTRL_BUBBLE) AND (EX_RDaddr_i != 0) AND ((EX_RDaddr_i == ID_RSaddr1_i) OR (ID_uses_rs2_i AND EX_RDaddr_i == ID_RSaddr2_i)).
- Priority:
  - branch_taken_i is asserted: flush. IF_ID_flush_o=1, hazard_o=1 (squashes the wrong-path ID instruction), pc_write_o=1, IF_ID_write_o=1. lu_raw is ignored.
  - Else lu_raw=1: stall. hazard_o=1, pc_write_o=0, IF_ID_write_o=0, IF_ID_flush_o=0.
  - Else: hazard_o=0, pc_write_o=1, IF_ID_write_o=1, IF_ID_flush_o=0.
- All four control outputs are combinational from the inputs (zero latency). ID/EX samples hazard_o on the same rising edge.
- FSM, state_o encoding: RUN=0, STALL=1, FLUSH=2. It is registered and advances each edge.
  - Any state -> FLUSH on branch_taken_i.
  - Else any state -> STALL on lu_raw.
  - Else -> RUN.
- Protocol check: lu_raw while state==STALL (a second consecutive load-use stall on the same pair) sets err_o. The bubble must have cleared EX, so this indicates broken bubble encoding upstream. err_o stays set until reset. The stall is still issued.
- Counters:
  - stall_cnt_o increments on each cycle that issues a stall.
  - flush_cnt_o increments on each cycle that issues a flush.
  - Both saturate at all-ones; they do not wrap.
- Reset (rst_i=1 at an edge): state=RUN, stall_cnt_o=0, flush_cnt_o=0, err_o=0. During the reset cycle the combinational outputs are forced to hazard_o=1, pc_write_o=0, IF_ID_write_o=0, IF_ID_flush_o=1, so the pipeline fills with bubbles. Reset mid-stall or mid-flush aborts it with no count.
- x0 is never a hazard source.
- EX holding a bubble (EX_control_i==CTRL_BUBBLE) is never a hazard source, even if EX_memread_i=1.

Decomposition:
- Shared pipeline package holds:
  - CTRL_BUBBLE
  - control-field width
  - the hazard_ctrl state encoding (RUN/STALL/FLUSH)
  - register-index width (5)
- One natural sub-module: sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o). It is instantiated twice.

Test Plan:
- Load x5 in EX (EX_memread_i=1, EX_RDaddr_i=5, EX_control_i=4'b0010), ID rs1=5 -> same cycle hazard_o=1, pc_write_o=0, IF_ID_write_o=0. Next cycle state_o=1, stall_cnt_o=1. With EX now a bubble, hazard_o=0.
- Load x0 in EX with ID rs1=0; separately EX_control_i=4'b1111 with memread=1 and rd=5, ID rs1=5 -> no stall, counters unchanged.
- ID rs2=7, ID_uses_rs2_i=0, load x7 in EX -> no stall. Same stimulus with ID_uses_rs2_i=1 -> stall.
- branch_taken_i=1 together with a matching load-use -> IF_ID_flush_o=1, hazard_o=1, pc_write_o=1. Next cycle state_o=2, flush_cnt_o=1, stall_cnt_o=0.
- Hold lu_raw true for 2 cycles -> err_o=1 from the second edge onward and stays set. Assert rst_i -> err_o=0, counters=0, state_o=0.
- CNT_W=2, issue 5 stalls (alternating with idle cycles) -> stall_cnt_o sequence 1,2,3,3,3.
